mem_bist_regfile: RTL and testbench
===================================

// Module: mem_bist_regfile
// PURPOSE
//  Parametrised successor to the 32x8 test register file: DEPTH x DATA_W storage with host
//  write port and two combinational read ports (addr, addr+1 with wrap), plus a built-in
//  March C- self-test engine and a read-path fault-injection hook. Sits directly behind
//  the chip pins of a memory-test tile; BIST lets silicon be checked without a host tester.
// PARAMETERS
//  DATA_W  8  word width in bits (>=1)
//  ADDR_W  5  address width; DEPTH = 2**ADDR_W words
// PORTS
//  clk        in   1       single clock, all state on rising edge
//  rst_n      in   1       reset, synchronous, active-low
//  wr_en      in   1       host write strobe
//  addr       in   ADDR_W  host address
//  wdata      in   DATA_W  host write data
//  rdata0     out  DATA_W  mem[addr] ^ inject, combinational
//  rdata1     out  DATA_W  mem[(addr+1) mod DEPTH] ^ inject, combinational
//  inj_addr   in   ADDR_W  fault-injection address
//  inj_mask   in   DATA_W  XOR applied to any read of inj_addr (0 = no fault)
//  bist_start in   1       level/pulse; sampled only in IDLE/DONE
//  bist_busy  out  1       high while March sequence runs
//  bist_done  out  1       sticky: sequence finished (pass or fail) until next start/reset
//  bist_pass  out  1       valid when bist_done; 1 = no mismatch
//  fail_addr  out  ADDR_W  address of first mismatch (0 if pass)
//  fail_elem  out  3       March element index (1..5) of first mismatch (0 if pass)
// BEHAVIOUR
//  - Reset: busy=done=pass=0, fail_addr=0, fail_elem=0, FSM=IDLE. Storage is NOT reset.
//  - Host write: mem[addr]<=wdata at edge when wr_en=1 and FSM not RUN (start cycle included).
//    wr_en during RUN ignored. Reads never blocked; during RUN rdata reflect live contents.
//  - addr+1 computed in ADDR_W bits: addr=DEPTH-1 -> rdata1 from address 0.
//  - Inject applies identically to host reads and BIST compares; storage itself untouched.
//  - FSM: IDLE -> RUN on bist_start (clears done/pass/fail_*); RUN -> DONE at end or first
//    mismatch; DONE -> RUN on bist_start; bist_start while RUN ignored.
//  - RUN steps elements E0..E5, one address per cycle, pattern Z=all-0, O=all-1:
//     E0 up   w Z      | E1 up r Z,w O | E2 up   r O,w Z
//     E3 down r Z,w O  | E4 down r O,w Z | E5 up r Z
//    up = 0..DEPTH-1, down = DEPTH-1..0. r,w in same cycle: compare combinational read
//    against expected, write at same edge (write suppressed on mismatch).
//  - Pass latency: busy high exactly 6*DEPTH cycles; done=1,pass=1,busy=0 the cycle after
//    last E5 compare. Memory left all-zero.
//  - Fail: on first mismatch, at that edge busy<=0, done<=1, pass<=0, fail_addr/fail_elem
//    captured; remaining sequence aborted; memory left partially written.
//  - Element/address counters wrap cleanly; down counter end detect at 0, up at DEPTH-1.
//  - rst_n low mid-RUN: FSM to IDLE, flags cleared, memory contents undefined.
// STRUCTURE
//  - Package mem_test_pkg: FSM state enum {IDLE,RUN,DONE}, element index localparams
//    E0..E5, per-element direction/read-expect/write-value table as functions.
//  - Sub-module mem_test_regfile: storage, write port, two read ports with inject XOR.
//    Top mem_bist_regfile: BIST FSM, counters, port muxing, result registers.
// TESTING (defaults DATA_W=8, ADDR_W=5)
//  1 write 0x11..0x30 to addr 0..31; addr=31 -> rdata0=0x30, rdata1=0x11; addr=4 -> 0x15,0x16
//  2 pulse bist_start, inj_mask=0 -> busy high 192 cycles, then done=1 pass=1; all reads 0x00
//  3 inj_addr=7 inj_mask=0x01, start -> done=1 pass=0 fail_addr=7 fail_elem=1
//  4 start, assert wr_en addr=3 wdata=0xA5 and re-pulse start at cycle 20 -> both ignored,
//    pass after 192 cycles, mem[3]=0x00; write same after done -> rdata0=0xA5
//  5 start, drop rst_n one cycle at cycle 50 -> busy=0 done=0 pass=0 next cycle, FSM IDLE
//  6 DATA_W=4 ADDR_W=2, inj_addr=3 inj_mask=0x8 -> fail_addr=3 fail_elem=1 after 8 cycles

Source files
------------

// File: rtl/mem_test_pkg.sv
// Shared types and the March C- element table for the BIST register file.
// Each element's direction, read expectation and write value are derived from its index.
package mem_test_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_t;

    localparam logic [2:0] E0 = 3'd0;
    localparam logic [2:0] E1 = 3'd1;
    localparam logic [2:0] E2 = 3'd2;
    localparam logic [2:0] E3 = 3'd3;
    localparam logic [2:0] E4 = 3'd4;
    localparam logic [2:0] E5 = 3'd5;

    function automatic logic elem_down(input logic [2:0] e);
        return (e == E3) || (e == E4);
    endfunction

    function automatic logic elem_reads(input logic [2:0] e);
        return e != E0;
    endfunction

    function automatic logic elem_read_ones(input logic [2:0] e);
        return (e == E2) || (e == E4);
    endfunction

    function automatic logic elem_writes(input logic [2:0] e);
        return e != E5;
    endfunction

    function automatic logic elem_write_ones(input logic [2:0] e);
        return (e == E1) || (e == E3);
    endfunction

endpackage

// File: rtl/mem_test_regfile.sv
// DEPTH x DATA_W storage: one write port, host read ports at addr and addr+1 (wrapping),
// plus a BIST check port. The inject mask corrupts reads of inj_addr only, never storage.
module mem_test_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    input  logic [ADDR_W-1:0] chk_addr,
    output logic [DATA_W-1:0] chk_data,
    input  logic [ADDR_W-1:0] inj_addr,
    input  logic [DATA_W-1:0] inj_mask
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] rd_addr_nxt;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    function automatic logic [DATA_W-1:0] fault_of(input logic [ADDR_W-1:0] a);
        return (a == inj_addr) ? inj_mask : '0;
    endfunction

    // Increment stays in ADDR_W bits so the top address wraps to 0.
    assign rd_addr_nxt = rd_addr + ADDR_W'(1);

    assign rdata0   = mem[rd_addr]     ^ fault_of(rd_addr);
    assign rdata1   = mem[rd_addr_nxt] ^ fault_of(rd_addr_nxt);
    assign chk_data = mem[chk_addr]    ^ fault_of(chk_addr);

endmodule

// File: rtl/mem_bist_regfile.sv
// Register file with a built-in March C- self-test; the BIST owns the write port while running.
//   state | meaning
//   IDLE  | after reset, host owns storage, waiting for bist_start
//   RUN   | stepping E0..E5, one address per cycle; host writes ignored
//   DONE  | result held (pass or first failure) until the next start
module mem_bist_regfile
    import mem_test_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    input  logic [ADDR_W-1:0] inj_addr,
    input  logic [DATA_W-1:0] inj_mask,
    input  logic              bist_start,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    bist_state_t       state;
    logic [2:0]        elem;
    logic [2:0]        elem_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              running;
    logic              mismatch;
    logic              last_addr;
    logic [DATA_W-1:0] chk_data;
    logic [DATA_W-1:0] exp_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    mem_test_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .wr_en    (mem_we),
        .wr_addr  (mem_waddr),
        .wr_data  (mem_wdata),
        .rd_addr  (addr),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .chk_addr (cnt),
        .chk_data (chk_data),
        .inj_addr (inj_addr),
        .inj_mask (inj_mask)
    );

    assign running  = (state == RUN);
    assign elem_nxt = elem + 3'd1;

    always_comb begin
        exp_data  = elem_read_ones(elem) ? '1 : '0;
        mismatch  = running && elem_reads(elem) && (chk_data != exp_data);
        last_addr = elem_down(elem) ? (cnt == '0) : (cnt == ADDR_MAX);
        mem_we    = wr_en;
        mem_waddr = addr;
        mem_wdata = wdata;
        // A failing compare must not also overwrite the cell it just flagged.
        if (running) begin
            mem_we    = elem_writes(elem) && !mismatch;
            mem_waddr = cnt;
            mem_wdata = elem_write_ones(elem) ? '1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            elem      <= E0;
            cnt       <= '0;
            bist_busy <= 1'b0;
            bist_done <= 1'b0;
            bist_pass <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bist_start) begin
                        state     <= RUN;
                        elem      <= E0;
                        cnt       <= '0;
                        bist_busy <= 1'b1;
                        bist_done <= 1'b0;
                        bist_pass <= 1'b0;
                        fail_addr <= '0;
                        fail_elem <= '0;
                    end
                end
                RUN: begin
                    if (mismatch) begin
                        state     <= DONE;
                        bist_busy <= 1'b0;
                        bist_done <= 1'b1;
                        bist_pass <= 1'b0;
                        fail_addr <= cnt;
                        fail_elem <= elem;
                    end else if (last_addr) begin
                        if (elem == E5) begin
                            state     <= DONE;
                            bist_busy <= 1'b0;
                            bist_done <= 1'b1;
                            bist_pass <= 1'b1;
                        end else begin
                            elem <= elem_nxt;
                            cnt  <= elem_down(elem_nxt) ? ADDR_MAX : '0;
                        end
                    end else begin
                        cnt <= elem_down(elem) ? cnt - ADDR_W'(1) : cnt + ADDR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bist_regfile.sv
// Randomised bench for mem_bist_regfile: an array-level March C- model predicts each run's
// outcome and length, and a per-cycle compare process checks flags and host reads against it.
module tb_mem_bist_regfile;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 2 ** AW;
    localparam int LIMIT = 1000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic [AW-1:0] inj_addr;
    logic [DW-1:0] inj_mask;
    logic          bist_start;
    logic          bist_busy;
    logic          bist_done;
    logic          bist_pass;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;

    // second, tiny instance: DATA_W=4, ADDR_W=2
    logic       s_rst_n;
    logic       s_wr_en;
    logic [1:0] s_addr;
    logic [3:0] s_wdata;
    logic [3:0] s_rdata0;
    logic [3:0] s_rdata1;
    logic [1:0] s_inj_addr;
    logic [3:0] s_inj_mask;
    logic       s_bist_start;
    logic       s_bist_busy;
    logic       s_bist_done;
    logic       s_bist_pass;
    logic [1:0] s_fail_addr;
    logic [2:0] s_fail_elem;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_bist_regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk), .rst_n (rst_n), .wr_en (wr_en), .addr (addr), .wdata (wdata),
        .rdata0 (rdata0), .rdata1 (rdata1), .inj_addr (inj_addr), .inj_mask (inj_mask),
        .bist_start (bist_start), .bist_busy (bist_busy), .bist_done (bist_done),
        .bist_pass (bist_pass), .fail_addr (fail_addr), .fail_elem (fail_elem)
    );

    mem_bist_regfile #(.DATA_W(4), .ADDR_W(2)) dut_s (
        .clk (clk), .rst_n (s_rst_n), .wr_en (s_wr_en), .addr (s_addr), .wdata (s_wdata),
        .rdata0 (s_rdata0), .rdata1 (s_rdata1), .inj_addr (s_inj_addr), .inj_mask (s_inj_mask),
        .bist_start (s_bist_start), .bist_busy (s_bist_busy), .bist_done (s_bist_done),
        .bist_pass (s_bist_pass), .fail_addr (s_fail_addr), .fail_elem (s_fail_elem)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_known [DEPTH];
    bit            m_busy, m_done, m_pass;
    logic [AW-1:0] m_fa;
    logic [2:0]    m_fe;
    int            m_left;
    bit            checking = 0;

    logic [DW-1:0] r_mem   [DEPTH];
    bit            r_known [DEPTH];
    bit            r_pass;
    logic [AW-1:0] r_fa;
    logic [2:0]    r_fe;
    int            r_cycles;

    function automatic logic [DW-1:0] inj_of(input int a);
        return (a == int'(inj_addr)) ? inj_mask : '0;
    endfunction

    // Run the whole March C- on a copy of the model memory; note outcome and step count.
    task automatic march_predict();
        r_mem    = m_mem;
        r_known  = m_known;
        r_pass   = 1;
        r_fa     = '0;
        r_fe     = '0;
        r_cycles = 0;
        for (int e = 0; e < 6 && r_pass; e++) begin
            for (int i = 0; i < DEPTH && r_pass; i++) begin : step_one
                int            a;
                logic [DW-1:0] seen;
                logic [DW-1:0] want;
                a    = (e == 3 || e == 4) ? DEPTH - 1 - i : i;
                seen = r_mem[a] ^ inj_of(a);
                want = (e == 2 || e == 4) ? {DW{1'b1}} : {DW{1'b0}};
                r_cycles++;
                if (e != 0 && seen !== want) begin
                    r_pass = 0;
                    r_fa   = a[AW-1:0];
                    r_fe   = e[2:0];
                end else if (e != 5) begin
                    r_mem[a]   = (e == 1 || e == 3) ? {DW{1'b1}} : {DW{1'b0}};
                    r_known[a] = 1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            if (m_busy) begin
                foreach (m_known[i]) m_known[i] = 0;
            end
            m_busy = 0; m_done = 0; m_pass = 0; m_fa = '0; m_fe = '0; m_left = 0;
            checking = 1;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy  = 0;
                m_done  = 1;
                m_pass  = r_pass;
                m_fa    = r_fa;
                m_fe    = r_fe;
                m_mem   = r_mem;
                m_known = r_known;
            end
        end else begin
            if (wr_en) begin
                m_mem[addr]   = wdata;
                m_known[addr] = 1;
            end
            if (bist_start) begin
                march_predict();
                m_busy = 1; m_done = 0; m_pass = 0; m_fa = '0; m_fe = '0;
                m_left = r_cycles;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin : cmp
            logic [AW-1:0] a1;
            a1 = addr + AW'(1);
            chk("busy", bist_busy, m_busy);
            chk("done", bist_done, m_done);
            chk("pass", bist_pass, m_pass);
            chk("fail_addr", fail_addr, m_fa);
            chk("fail_elem", fail_elem, m_fe);
            if (!m_busy && m_known[addr]) chk("rdata0", rdata0, m_mem[addr] ^ inj_of(addr));
            if (!m_busy && m_known[a1])   chk("rdata1", rdata1, m_mem[a1] ^ inj_of(a1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // poke_at: cycle to attempt a host write + restart; rst_at: cycle to pulse reset;
    // noisy: random writes/starts while running.
    task automatic run_bist(input int poke_at, input int rst_at, input bit noisy, output int cycles);
        bist_start = 1;
        step();
        bist_start = 0;
        cycles = 0;
        while (bist_busy && cycles < LIMIT) begin
            if (noisy) begin
                wr_en      = 1'($urandom);
                addr       = AW'($urandom);
                wdata      = DW'($urandom);
                bist_start = 1'($urandom);
            end
            if (cycles == poke_at) begin
                wr_en = 1; addr = 3; wdata = 8'hA5; bist_start = 1;
            end
            if (cycles == rst_at) rst_n = 0;
            step();
            cycles++;
            wr_en = 0; bist_start = 0; rst_n = 1;
        end
        if (cycles >= LIMIT) chk("bist_timeout", 32'(cycles), 0);
    endtask

    task automatic s_run(output int cycles);
        s_bist_start = 1;
        step();
        s_bist_start = 0;
        cycles = 0;
        while (s_bist_busy && cycles < LIMIT) begin
            step();
            cycles++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n = 0; wr_en = 0; addr = '0; wdata = '0; inj_addr = '0; inj_mask = '0; bist_start = 0;
        s_rst_n = 0; s_wr_en = 0; s_addr = '0; s_wdata = '0; s_inj_addr = '0; s_inj_mask = '0;
        s_bist_start = 0;
        step(); step();
        chk("rst_busy", bist_busy, 0);
        chk("rst_done", bist_done, 0);
        chk("rst_pass", bist_pass, 0);
        chk("rst_fail_addr", fail_addr, 0);
        chk("rst_fail_elem", fail_elem, 0);
        rst_n = 1; s_rst_n = 1;
        step();

        // 1: fill 0x11..0x30, check wrap read port
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1; addr = AW'(i); wdata = DW'(8'h11 + i);
            step();
        end
        wr_en = 0;
        addr = 31; #1;
        chk("t1_rdata0_31", rdata0, 8'h30);
        chk("t1_rdata1_31", rdata1, 8'h11);
        addr = 4; #1;
        chk("t1_rdata0_4", rdata0, 8'h15);
        chk("t1_rdata1_4", rdata1, 8'h16);
        step();

        // 2: clean run
        run_bist(-1, -1, 0, cyc);
        chk("t2_cycles", 32'(cyc), 192);
        chk("t2_done", bist_done, 1);
        chk("t2_pass", bist_pass, 1);
        for (int i = 0; i < DEPTH; i++) begin
            addr = AW'(i); #1;
            chk("t2_zero", rdata0, 8'h00);
        end
        step();

        // 3: single-bit fault at address 7
        inj_addr = 7; inj_mask = 8'h01;
        step();
        run_bist(-1, -1, 0, cyc);
        chk("t3_cycles", 32'(cyc), 40);
        chk("t3_done", bist_done, 1);
        chk("t3_pass", bist_pass, 0);
        chk("t3_fail_addr", fail_addr, 7);
        chk("t3_fail_elem", fail_elem, 1);
        inj_mask = '0;
        step();

        // 4: host write and restart while running are ignored
        run_bist(20, -1, 0, cyc);
        chk("t4_cycles", 32'(cyc), 192);
        chk("t4_pass", bist_pass, 1);
        addr = 3; #1;
        chk("t4_mem3_zero", rdata0, 8'h00);
        wr_en = 1; addr = 3; wdata = 8'hA5;
        step();
        wr_en = 0; #1;
        chk("t4_mem3_a5", rdata0, 8'hA5);
        step();

        // 5: reset mid-run
        run_bist(-1, 50, 0, cyc);
        chk("t5_cycles", 32'(cyc), 51);
        chk("t5_busy", bist_busy, 0);
        chk("t5_done", bist_done, 0);
        chk("t5_pass", bist_pass, 0);
        step();

        // randomised traffic and BIST runs
        for (int it = 0; it < 24; it++) begin
            int n;
            n = $urandom_range(40, 10);
            for (int k = 0; k < n; k++) begin
                wr_en = 1'($urandom); addr = AW'($urandom); wdata = DW'($urandom);
                step();
            end
            wr_en = 0;
            inj_addr = AW'($urandom);
            inj_mask = ($urandom_range(2, 0) == 0) ? DW'($urandom) : '0;
            step();
            run_bist(-1, ($urandom_range(5, 0) == 0) ? int'($urandom_range(150, 1)) : -1,
                     1'($urandom), cyc);
            inj_mask = '0;
            for (int k = 0; k < 8; k++) begin
                addr = AW'($urandom);
                step();
            end
        end

        // 6: small instance, fault at last address
        s_inj_addr = 3; s_inj_mask = 4'h8;
        step();
        s_run(cyc);
        chk("t6_cycles", 32'(cyc), 8);
        chk("t6_done", s_bist_done, 1);
        chk("t6_pass", s_bist_pass, 0);
        chk("t6_fail_addr", s_fail_addr, 3);
        chk("t6_fail_elem", s_fail_elem, 1);
        s_inj_mask = '0;
        step();
        s_run(cyc);
        chk("t6_clean_cycles", 32'(cyc), 24);
        chk("t6_clean_pass", s_bist_pass, 1);
        chk("t6_clean_fail_elem", s_fail_elem, 0);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
